// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction fetch stage. Issues one instruction-memory request
//               at a time, fills the IF/ID register and gates PC advance.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        id_stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        fetch_stall_o,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_WAIT = 2'd1;
   localparam logic [1:0] c_ST_HOLD = 2'd2;
   localparam logic [1:0] c_ST_DROP = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_req_pc;
   logic [31:0] r_hold_pc;
   logic [31:0] r_hold_instr;
   logic        r_id_valid;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_instr;
   logic        w_resp_wait;
   logic        w_deliver_mem;
   logic        w_deliver_hold;
   logic        w_capture_hold;

   // Responses are only meaningful while a request is outstanding (WAIT/DROP)
   assign w_resp_wait    = (r_state == c_ST_WAIT) && imem_rvalid_i;
   assign w_deliver_mem  = w_resp_wait && !flush_i && !id_stall_i;
   assign w_capture_hold = w_resp_wait && !flush_i && id_stall_i;
   assign w_deliver_hold = (r_state == c_ST_HOLD) && !flush_i && !id_stall_i;

   assign imem_req_o    = (r_state == c_ST_IDLE) && !flush_i;
   assign imem_addr_o   = pc_i;
   // PC moves on a redirect or exactly when an instruction enters IF/ID
   assign fetch_stall_o = !(flush_i || w_deliver_mem || w_deliver_hold);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (!flush_i) w_state_nxt = c_ST_WAIT;
         end
         c_ST_WAIT: begin
            if (flush_i)            w_state_nxt = imem_rvalid_i ? c_ST_IDLE : c_ST_DROP;
            else if (imem_rvalid_i) w_state_nxt = id_stall_i ? c_ST_HOLD : c_ST_IDLE;
         end
         c_ST_HOLD: begin
            if (flush_i || !id_stall_i) w_state_nxt = c_ST_IDLE;
         end
         c_ST_DROP: begin
            if (imem_rvalid_i) w_state_nxt = c_ST_IDLE;
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_ST_IDLE;
         r_req_pc     <= 32'd0;
         r_hold_pc    <= 32'd0;
         r_hold_instr <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (imem_req_o) r_req_pc <= pc_i;
         if (w_capture_hold) begin
            r_hold_pc    <= r_req_pc;
            r_hold_instr <= imem_rdata_i;
         end
      end
   end

   // IF/ID register: flush beats stall, stall beats delivery
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_valid <= 1'b0;
         r_id_pc    <= 32'd0;
         r_id_instr <= NOP_INSTR;
      end else if (flush_i) begin
         r_id_valid <= 1'b0;
      end else if (!id_stall_i) begin
         if (w_deliver_mem) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_req_pc;
            r_id_instr <= imem_rdata_i;
         end else if (w_deliver_hold) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_hold_pc;
            r_id_instr <= r_hold_instr;
         end else begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign id_valid_o = r_id_valid;
   assign id_pc_o    = r_id_pc;
   assign id_instr_o = r_id_instr;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Scoreboard bench for if_fetch_stage with a variable-latency
//               memory model, a PC register model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

   localparam logic [31:0] c_NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        id_stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        fetch_stall_o;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_instr_o;

   if_fetch_stage #(.NOP_INSTR(c_NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .id_stall_i    (id_stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .fetch_stall_o (fetch_stall_o),
      .id_valid_o    (id_valid_o),
      .id_pc_o       (id_pc_o),
      .id_instr_o    (id_instr_o)
   );

   always #5 clk = ~clk;

   item_t       sb_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_deliv  = 0;
   logic        mem_busy, mem_killed;
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic        adv;
   logic        stray;
   logic [31:0] stray_data;
   logic        obs_req, obs_fstall;
   logic [31:0] obs_addr;
   logic        mon_deliv;
   logic        pv_valid;
   logic [31:0] pv_pc, pv_instr;
   item_t       mon_it;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h01000193) ^ 32'h00500093;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: checks IF/ID after every edge against the scoreboard and the hold/flush rules
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            mon_deliv = id_valid_o && !flush_i && !id_stall_i;
            chk("pc_advance_matches_delivery", 32'(mon_deliv), 32'(adv));
            if (flush_i) begin
               chk("flush_clears_valid", 32'(id_valid_o), 32'd0);
            end else if (id_stall_i) begin
               chk("stall_holds_valid", 32'(id_valid_o), 32'(pv_valid));
               chk("stall_holds_pc", id_pc_o, pv_pc);
               chk("stall_holds_instr", id_instr_o, pv_instr);
            end else if (id_valid_o) begin
               n_deliv++;
               if (sb_q.size() == 0) begin
                  chk("unexpected_delivery_pc", id_pc_o, 32'hxxxxxxxx);
               end else begin
                  mon_it = sb_q.pop_front();
                  chk("deliver_pc", id_pc_o, mon_it.pc);
                  chk("deliver_instr", id_instr_o, mon_it.instr);
               end
            end
         end
         pv_valid = id_valid_o;
         pv_pc    = id_pc_o;
         pv_instr = id_instr_o;
      end
   end

   // One clock of stimulus: drive, observe combinational outputs, update memory/PC/scoreboard
   task automatic step(input logic fl, input logic [31:0] npc, input logic st, input int lat);
      logic        rv;
      logic [31:0] pc_nxt;
      rv            = mem_busy && (mem_cnt == 0);
      flush_i       = fl;
      id_stall_i    = st;
      imem_rvalid_i = rv || stray;
      imem_rdata_i  = rv ? mem_data(mem_addr) : stray_data;
      #1;
      obs_req    = imem_req_o;
      obs_addr   = imem_addr_o;
      obs_fstall = fetch_stall_o;
      adv        = !fl && !obs_fstall;
      if (fl) sb_q.delete();
      if (rv) begin
         if (!mem_killed && !fl) sb_q.push_back({mem_addr, mem_data(mem_addr)});
         mem_busy = 1'b0;
      end else if (mem_busy) begin
         if (fl) mem_killed = 1'b1;
         mem_cnt--;
      end
      if (obs_req) begin
         chk("single_outstanding", 32'(mem_busy), 32'd0);
         chk("req_addr_is_pc", obs_addr, pc_i);
         mem_busy   = 1'b1;
         mem_killed = 1'b0;
         mem_cnt    = lat - 1;
         mem_addr   = obs_addr;
      end
      if (fl)              pc_nxt = npc;
      else if (!obs_fstall) pc_nxt = pc_i + 32'd4;
      else                 pc_nxt = pc_i;
      @(posedge clk);
      #2;
      pc_i          = pc_nxt;
      stray         = 1'b0;
      imem_rvalid_i = 1'b0;
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0; id_stall_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
      pc_i = 32'd0; adv = 1'b0; mem_busy = 1'b0; mem_killed = 1'b0; mem_cnt = 0;
      mem_addr = 32'd0; stray = 1'b0; stray_data = 32'd0;
      sb_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(id_valid_o), 32'd0);
      chk("reset_pc", id_pc_o, 32'd0);
      chk("reset_instr", id_instr_o, c_NOP);
      #1;
      rst = 1'b0;

      // single-cycle memory
      step(0, 0, 0, 1);
      chk("c1_req", 32'(obs_req), 32'd1);
      chk("c1_addr", obs_addr, 32'd0);
      step(0, 0, 0, 1);
      chk("c2_fstall", 32'(obs_fstall), 32'd0);
      chk("c2_valid", 32'(id_valid_o), 32'd1);
      chk("c2_pc", id_pc_o, 32'd0);
      chk("c2_instr", id_instr_o, 32'h00500093);
      // 3-cycle latency
      step(0, 0, 0, 3);
      chk("lat3_req_addr", obs_addr, 32'd4);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 1);
         chk("lat3_wait_fstall", 32'(obs_fstall), 32'd1);
         chk("lat3_wait_req", 32'(obs_req), 32'd0);
         chk("lat3_wait_bubble", 32'(id_valid_o), 32'd0);
      end
      step(0, 0, 0, 1);
      chk("lat3_deliver_pc", id_pc_o, 32'd4);
      // response at pc 8 while decode stalls for 3 cycles
      step(0, 0, 0, 1);
      chk("hold_req_addr", obs_addr, 32'd8);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1);
         chk("hold_fstall", 32'(obs_fstall), 32'd1);
         chk("hold_ifid_pc", id_pc_o, 32'd4);
      end
      step(0, 0, 0, 1);
      chk("hold_release_fstall", 32'(obs_fstall), 32'd0);
      chk("hold_release_pc", id_pc_o, 32'd8);
      step(0, 0, 0, 1);
      chk("after_hold_req_addr", obs_addr, 32'd12);
      step(0, 0, 0, 1);
      // flush while waiting for pc 0x10
      step(0, 0, 0, 3);
      chk("drop_req_addr", obs_addr, 32'h10);
      step(1, 32'h40, 0, 1);
      chk("drop_flush_fstall", 32'(obs_fstall), 32'd0);
      step(0, 0, 0, 1);
      chk("drop_no_req", 32'(obs_req), 32'd0);
      step(0, 0, 0, 1);
      chk("drop_late_resp_hidden", 32'(id_valid_o), 32'd0);
      step(0, 0, 0, 1);
      chk("redirect_req_addr", obs_addr, 32'h40);
      // flush together with rvalid
      step(1, 32'h80, 0, 1);
      chk("flush_rvalid_fstall", 32'(obs_fstall), 32'd0);
      chk("flush_rvalid_valid", 32'(id_valid_o), 32'd0);
      step(0, 0, 0, 3);
      chk("flush_rvalid_next_req", obs_addr, 32'h80);
      step(0, 0, 0, 1);
      // reset mid-WAIT, stray response just after release
      #1;
      rst = 1'b1;
      idle_inputs();
      #1;
      chk("midrst_valid", 32'(id_valid_o), 32'd0);
      chk("midrst_instr", id_instr_o, c_NOP);
      @(posedge clk);
      #2;
      rst        = 1'b0;
      stray      = 1'b1;
      stray_data = 32'hDEADBEEF;
      step(0, 0, 0, 1);
      chk("stray_req", 32'(obs_req), 32'd1);
      chk("stray_req_addr", obs_addr, 32'd0);
      chk("stray_ignored", 32'(id_valid_o), 32'd0);
      step(0, 0, 0, 1);
      chk("post_rst_instr", id_instr_o, 32'h00500093);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
              32'($urandom_range(0, 1023)) << 2,
              ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
              int'($urandom_range(1, 4)));
      end
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      chk("deliveries_seen", 32'(n_deliv > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage between the PC register and the decode stage.
- Takes the current PC and issues one request at a time to instruction memory, which has variable latency.
- Captures the returned instruction into the IF/ID pipeline register, or buffers it while decode is stalled.
- Drives the PC register's stall input so the PC advances only when an instruction has been handed to decode or a redirect occurs.

Parameters:
NOP_INSTR, 32'h00000013, bubble instruction presented on id_instr_o when id_valid_o=0 after reset.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active high
pc_i  input  32  current PC from PC register
flush_i  input  1  branch/jump redirect; PC loads NPC this cycle
id_stall_i  input  1  decode stage cannot accept a new instruction
imem_req_o  output  1  request strobe to instruction memory (combinational)
imem_addr_o  output  32  request address, equals pc_i
imem_rvalid_i  input  1  response valid, one cycle
imem_rdata_i  input  32  response instruction
fetch_stall_o  output  1  to PC stall input; 1 = hold PC
id_valid_o  output  1  IF/ID register holds a live instruction
id_pc_o  output  32  PC of instruction in IF/ID
id_instr_o  output  32  instruction in IF/ID

Behaviour:
- Reset: async, active high.
  - State=IDLE, id_valid_o=0, id_pc_o=0, id_instr_o=NOP_INSTR, hold buffer cleared, req_pc=0.
- FSM states: IDLE, WAIT, HOLD, DROP. At most one outstanding request.
- imem_rvalid_i is honoured only in WAIT and DROP. It is ignored in IDLE and HOLD, which covers stray responses after reset.
- IDLE:
  - imem_req_o = ~flush_i; imem_addr_o = pc_i.
  - If a request is issued: latch req_pc<=pc_i, go to WAIT.
  - On flush_i: no request, stay in IDLE.
- WAIT, without rvalid:
  - flush_i=0: stay in WAIT.
  - flush_i=1: go to DROP.
- WAIT, with rvalid:
  - flush_i=1: discard the response, go to IDLE.
  - id_stall_i=0: id_pc_o<=req_pc, id_instr_o<=imem_rdata_i, id_valid_o<=1, go to IDLE.
  - id_stall_i=1: store {req_pc, rdata} in the hold buffer, go to HOLD.
- HOLD:
  - flush_i=1: discard the buffer, go to IDLE.
  - id_stall_i=0: move the buffer into IF/ID with valid=1, go to IDLE.
  - Otherwise stay in HOLD.
- DROP:
  - Wait for the pending response; on rvalid discard it and go to IDLE.
  - flush_i in DROP keeps the state in DROP.
- fetch_stall_o (combinational):
  - 0 when flush_i=1, so the PC loads NPC.
  - 0 in WAIT when rvalid=1 and id_stall_i=0.
  - 0 in HOLD when id_stall_i=0.
  - 1 in all other cases.
  - Effect: the PC advances exactly once per delivered instruction.
- IF/ID register updates:
  - flush_i=1: id_valid_o<=0; id_pc_o/id_instr_o may hold.
  - id_stall_i=1 and no flush: all IF/ID outputs hold.
  - id_stall_i=0 and no delivery this cycle: id_valid_o<=0 (bubble); pc/instr hold.
- Precedence: flush_i over id_stall_i, and id_stall_i over delivery.
- Simultaneous flush_i and rvalid in WAIT: the response is discarded and the next request in IDLE uses the redirected PC.
- Reset mid-request: the FSM returns to IDLE and a new request for the reset PC is issued the following cycle. The old response, arriving in IDLE, is ignored.
- Minimum throughput: one instruction per 2 cycles with single-cycle memory (IDLE→WAIT→IDLE).

Test Plan:
- Reset, then single-cycle memory returning 0x00500093 for addr 0:
  - Required: req at addr 0 in cycle 1.
  - Required: id_valid=1, id_pc=0, id_instr=0x00500093 after the response edge.
  - Required: fetch_stall=0 in the response cycle; next req at addr 4.
- 3-cycle memory latency:
  - Required: fetch_stall=1 and imem_req_o=0 for 2 wait cycles.
  - Required: id_valid=0 (bubbles) during the wait.
  - Required: delivery on the third cycle.
- Response at pc=8 arrives while id_stall_i=1 for 3 cycles:
  - Required: FSM in HOLD, fetch_stall=1, IF/ID unchanged.
  - Required: when the stall drops, id_pc=8 is loaded and the next req is at 12.
- flush_i while in WAIT for pc=0x10, NPC=0x40:
  - Required: DROP state; the late response for 0x10 never appears in IF/ID.
  - Required: next req at 0x40.
- flush_i in the same cycle as rvalid:
  - Required: id_valid=0 and no instruction delivered.
  - Required: fetch_stall=0, next req at the new PC.
- rst asserted mid-WAIT, stray rvalid one cycle after release:
  - Required: outputs at reset values; stray response ignored.
  - Required: fresh req at addr 0.
